acondicionador_botones: RTL and testbench

//  Upstream stage of the tic-tac-toe controller. Takes five raw pushbuttons:
//  up, down, left, right and select. Each button is synchronised, debounced
//  and reduced to a single one-cycle pulse per press. A priority arbiter then

---
 rtl/acondicionador_botones.sv | 109 ++++++++++
 tb/tb_acondicionador_botones.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_botones.sv
// Button conditioner for the tic-tac-toe controller.
// Five raw pushbuttons are polarity-corrected, synchronised and debounced,
// and each accepted press becomes one pending request. A registered priority
// arbiter serves at most one request per clock as a one-cycle pulse.
module acondicionador_botones #(
  parameter int DB_CYCLES   = 500000,
  parameter int CNT_W       = 19,
  parameter bit ACTIVO_ALTO = 1'b1
) (
  input  logic       clk,
  input  logic       reset_all_n,
  input  logic [4:0] btn_raw,
  input  logic       habilita,
  output logic       boton_elige_reg,
  output logic       boton_arriba_reg,
  output logic       boton_abajo_reg,
  output logic       boton_izq_reg,
  output logic       boton_der_reg,
  output logic [4:0] boton_nivel
);

  // Count value at which a disagreeing synchronised level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [4:0] w_pol;
  logic [4:0] r_s1;
  logic [4:0] r_s2;
  logic [4:0] w_db;
  logic [4:0] w_rise;
  logic [4:0] w_grant;
  logic [4:0] r_pend;
  logic [4:0] r_pulse;

  // After this point 1 always means "pressed", whatever the board wiring.
  assign w_pol = ACTIVO_ALTO ? btn_raw : ~btn_raw;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_pol;
      r_s2 <= r_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_db
      logic [CNT_W-1:0] r_cnt;
      logic             r_db;

      // Debounce: count consecutive disagreeing cycles; any bounce back restarts at 0.
      always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
          r_cnt <= '0;
          r_db  <= 1'b0;
        end else if (r_s2[gi] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_db  <= r_s2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_db[gi]   = r_db;
      // Press event: the debounced level is about to rise on this edge.
      assign w_rise[gi] = r_s2[gi] && !r_db && (r_cnt == CNT_MAX);
    end
  endgenerate

  // Fixed priority: bit 4 (elige) highest down to bit 0 (der).
  always_comb begin
    logic w_found;
    w_found = 1'b0;
    w_grant = '0;
    for (int j = 4; j >= 0; j--) begin
      if (r_pend[j] && !w_found) begin
        w_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Pending requests and registered pulses; habilita low flushes both.
  always_ff @(posedge clk or negedge reset_all_n) begin
    if (!reset_all_n) begin
      r_pend  <= '0;
      r_pulse <= '0;
    end else if (!habilita) begin
      r_pend  <= '0;
      r_pulse <= '0;
    end else begin
      r_pend  <= (r_pend & ~w_grant) | w_rise;
      r_pulse <= w_grant;
    end
  end

  assign boton_elige_reg  = r_pulse[4];
  assign boton_arriba_reg = r_pulse[3];
  assign boton_abajo_reg  = r_pulse[2];
  assign boton_izq_reg    = r_pulse[1];
  assign boton_der_reg    = r_pulse[0];
  assign boton_nivel      = w_db;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with DB_CYCLES=4.
// Edge numbering: the first rising edge after an input change is edge 1, so a
// clean press raises the level after edge 6 and pulses after edge 7.
module tb_acondicionador_botones;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw;
  logic [4:0] raw_n;
  logic       hab;

  logic       e_a, a_a, b_a, i_a, d_a;
  logic [4:0] niv_a;
  logic       e_n, a_n, b_n, i_n, d_n;
  logic [4:0] niv_n;
  logic [4:0] pul_a;
  logic [4:0] pul_n;

  int checks;
  int failures;

  assign pul_a = {e_a, a_a, b_a, i_a, d_a};
  assign pul_n = {e_n, a_n, b_n, i_n, d_n};

  acondicionador_botones #(.DB_CYCLES(4), .CNT_W(2), .ACTIVO_ALTO(1'b1)) u_dut (
    .clk(clk), .reset_all_n(rst_n), .btn_raw(raw), .habilita(hab),
    .boton_elige_reg(e_a), .boton_arriba_reg(a_a), .boton_abajo_reg(b_a),
    .boton_izq_reg(i_a), .boton_der_reg(d_a), .boton_nivel(niv_a)
  );

  acondicionador_botones #(.DB_CYCLES(4), .CNT_W(2), .ACTIVO_ALTO(1'b0)) u_dut_n (
    .clk(clk), .reset_all_n(rst_n), .btn_raw(raw_n), .habilita(hab),
    .boton_elige_reg(e_n), .boton_arriba_reg(a_n), .boton_abajo_reg(b_n),
    .boton_izq_reg(i_n), .boton_der_reg(d_n), .boton_nivel(niv_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    raw      = 5'h00;
    raw_n    = 5'h1f;
    hab      = 1'b1;

    // Reset state
    tick(2);
    check("rst_pulse", pul_a, 5'h00);
    check("rst_nivel", niv_a, 5'h00);
    check("rst_pulse_n", pul_n, 5'h00);
    rst_n = 1'b1;
    tick(3);

    // 1. Clean press of arriba
    raw[3] = 1'b1;
    tick(5);
    check("t1_nivel_pre", niv_a, 5'h00);
    tick(1);
    check("t1_nivel", niv_a, 5'h08);
    check("t1_pre", pul_a, 5'h00);
    tick(1);
    check("t1_pulse", pul_a, 5'h08);
    tick(1);
    check("t1_post", pul_a, 5'h00);
    tick(12);
    raw[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t1_release", pul_a, 5'h00);
    end
    check("t1_nivel_off", niv_a, 5'h00);

    // 2. Bouncing der: short highs never reach the threshold
    raw[0] = 1'b1; tick(1); check("t2_bounce", pul_a, 5'h00); tick(1);
    raw[0] = 1'b0; tick(2);
    raw[0] = 1'b1; tick(1); check("t2_bounce", pul_a, 5'h00); tick(1);
    raw[0] = 1'b0; tick(1); check("t2_bnc_niv", niv_a, 5'h00); tick(1);
    raw[0] = 1'b1;
    tick(6);
    check("t2_pre", pul_a, 5'h00);
    check("t2_nivel", niv_a, 5'h01);
    tick(1);
    check("t2_pulse", pul_a, 5'h01);
    tick(1);
    check("t2_post", pul_a, 5'h00);
    raw[0] = 1'b0;
    tick(10);

    // 3. Simultaneous elige + izq: served one per cycle in priority order
    raw[4] = 1'b1; raw[1] = 1'b1;
    tick(6);
    check("t3_pre", pul_a, 5'h00);
    tick(1);
    check("t3_elige", pul_a, 5'h10);
    tick(1);
    check("t3_izq", pul_a, 5'h02);
    tick(1);
    check("t3_post", pul_a, 5'h00);
    raw[4] = 1'b0; raw[1] = 1'b0;
    tick(10);

    // 3b. habilita drop flushes requests already pending
    raw[4] = 1'b1; raw[1] = 1'b1;
    tick(6);
    hab = 1'b0;
    tick(1);
    check("t3b_flush", pul_a, 5'h00);
    hab = 1'b1;
    tick(1);
    check("t3b_flush2", pul_a, 5'h00);
    tick(1);
    check("t3b_flush3", pul_a, 5'h00);
    raw[4] = 1'b0; raw[1] = 1'b0;
    tick(10);

    // 4. Press while disabled, enable while held, then re-press
    hab = 1'b0;
    raw[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t4_disabled", pul_a, 5'h00);
    end
    check("t4_nivel", niv_a, 5'h04);
    hab = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t4_held", pul_a, 5'h00);
    end
    raw[2] = 1'b0;
    tick(8);
    check("t4_nivel_off", niv_a, 5'h00);
    raw[2] = 1'b1;
    tick(6);
    check("t4_pre", pul_a, 5'h00);
    tick(1);
    check("t4_pulse", pul_a, 5'h04);
    tick(1);
    check("t4_post", pul_a, 5'h00);
    raw[2] = 1'b0;
    tick(10);

    // 5. Reset between level rise and pulse; button held through reset
    raw[3] = 1'b1;
    tick(6);
    check("t5_nivel", niv_a, 5'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_p", pul_a, 5'h00);
    check("t5_async_n", niv_a, 5'h00);
    tick(2);
    check("t5_in_rst", pul_a, 5'h00);
    rst_n = 1'b1;
    tick(6);
    check("t5_pre", pul_a, 5'h00);
    tick(1);
    check("t5_pulse", pul_a, 5'h08);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t5_once", pul_a, 5'h00);
    end
    raw[3] = 1'b0;
    tick(10);

    // 6. Active-low instance: idle all-ones, then press elige
    check("t6_idle_p", pul_n, 5'h00);
    check("t6_idle_n", niv_n, 5'h00);
    raw_n[4] = 1'b0;
    tick(6);
    check("t6_pre", pul_n, 5'h00);
    check("t6_nivel", niv_n, 5'h10);
    tick(1);
    check("t6_pulse", pul_n, 5'h10);
    tick(1);
    check("t6_post", pul_n, 5'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
